vector_fetch_unit: RTL and testbench
====================================

# vector_fetch_unit

Fetch/decode stage that sits directly downstream of the vector machine's dual-read-port `Memory_Unit`. It drives both memory address ports and walks a 9-bit program counter. Each instruction word is split into fields, and the 24-bit operand named by the instruction's address field is fetched. One decoded instruction at a time is handed to the execute stage over a valid/ready handshake. Execute can redirect the PC (branch/jump), and an all-zero instruction word halts the unit.

## Interface
- `WORD_W`, 24, memory word width
- `ADDR_W`, 9, memory address width (512 words)
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `start` in 1, one-cycle pulse that begins fetching at `start_pc`
- `start_pc` in ADDR_W, first instruction address
- `mem_addr1` out ADDR_W, to memory `address1` (instruction port)
- `mem_addr2` out ADDR_W, to memory `address2` (operand port)
- `mem_data1` in WORD_W, from memory `data_out1`, combinational same-cycle read
- `mem_data2` in WORD_W, from memory `data_out2`, combinational same-cycle read
- `out_valid` out 1, decoded instruction available
- `out_ready` in 1, execute stage accepts
- `out_opcode` out 4, instr[23:20]
- `out_rd` out 3, instr[19:17]
- `out_rs1` out 3, instr[16:14]
- `out_rs2` out 3, instr[13:11]
- `out_addr` out ADDR_W, instr[8:0]; instr[10:9] are reserved and ignored
- `out_operand` out WORD_W, mem[instr[8:0]]
- `out_pc` out ADDR_W, address of the issued instruction
- `redirect_valid` in 1, execute requests a PC change
- `redirect_pc` in ADDR_W, new PC
- `halted` out 1, unit is in HALT

## Operation
- States: IDLE, FETCH, OPER, ISSUE, HALT.
- IDLE
  - `start` → FETCH with pc=`start_pc`.
- FETCH
  - `mem_addr1`=pc.
  - If `mem_data1`==0 → HALT.
  - Otherwise latch the word into `instr_q` → OPER.
- OPER
  - `mem_addr2`=`instr_q[8:0]`.
  - Latch `mem_data2` into `operand_q`.
  - pc ← pc+1, wrapping 511→0.
  - → ISSUE.
- ISSUE
  - `out_valid`=1; all `out_*` come from registers and are stable while valid and not accepted.
  - On `out_valid && out_ready` → FETCH.
- HALT
  - `halted`=1.
  - `start` → FETCH with `start_pc`.
- Redirect, in any state except IDLE
  - Next state is FETCH with pc=`redirect_pc`.
  - Any un-accepted ISSUE is dropped, and `out_valid` deasserts the next cycle.
  - If accepted and redirected in the same cycle, the instruction counts as consumed and the redirect still applies.
- Priority: `rst` > `redirect_valid` > `start` > normal transitions.
- `start` outside IDLE/HALT is ignored.
- `redirect_valid` in IDLE is ignored.
- While not driving a live address, `mem_addr1`/`mem_addr2` hold their last value; they are registered-or-muxed from state, and glitch-free values are not required.

## Timing
- Reset values: state=IDLE, pc=0, `out_valid`=0, `halted`=0, all `out_*` fields 0, `mem_addr1`=`mem_addr2`=0.
- Latency: `start` sampled at edge N → FETCH in cycle N+1, OPER in N+2, `out_valid` in N+3.
- Throughput: one instruction per 3 cycles when `out_ready` is held high.
- Reset asserted mid-instruction clears everything immediately (asynchronously); no partial output survives.

## Structure
- Shared package `vm_pkg`, containing:
  - `WORD_W`, `ADDR_W`
  - field bit positions (`OPC_HI`/`OPC_LO`, etc.)
  - state encoding enum
  - `OPC_HALT` = 4'h0
- Sub-module `instr_decode`: purely combinational field split of a 24-bit word, reused by execute.
- The FSM, PC, and output registers live in `vector_fetch_unit`.

## Test plan
- Decode fields:
  - Stimulus: mem[3]=24'b110111110000000000000101, mem[5]=17; pulse `start` with `start_pc`=3; `out_ready`=1.
  - Required: `out_valid` at N+3 with opcode=4'hD, rd=7, rs1=4, rs2=0, addr=5, operand=17, pc=3.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in ISSUE.
  - Required: outputs stable and `mem_addr1` not advanced; on `out_ready`=1 the next FETCH has pc=4.
- Halt on zero word:
  - Stimulus: mem[4]=0, run from pc 3.
  - Required: after issuing pc 3, `halted`=1 and `out_valid` never rises for pc 4.
  - Follow-up: `start` with `start_pc`=7 → resumes, and `out_pc`=7 issues.
- Redirect:
  - Stimulus: assert `redirect_valid` with `redirect_pc`=13 during ISSUE with `out_ready`=0.
  - Required: `out_valid` drops next cycle, `mem_addr1`=13 in FETCH, next `out_pc`=13.
- Wrap and reset:
  - Stimulus: non-zero instruction at 511, `start_pc`=511.
  - Required: after issue, FETCH uses pc=0.
  - Follow-up: assert `rst` during OPER → all outputs 0 and state IDLE in the same cycle.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the vector machine: widths, instruction field
// positions, the fetch-unit state encoding and the decoded instruction layout.
package vm_pkg;

  localparam int WORD_W = 24;
  localparam int ADDR_W = 9;

  // Instruction field bit positions (bits [10:9] are reserved)
  localparam int OPC_HI = 23;
  localparam int OPC_LO = 20;
  localparam int RD_HI  = 19;
  localparam int RD_LO  = 17;
  localparam int RS1_HI = 16;
  localparam int RS1_LO = 14;
  localparam int RS2_HI = 13;
  localparam int RS2_LO = 11;
  localparam int ADR_HI = 8;
  localparam int ADR_LO = 0;

  localparam logic [3:0] OPC_HALT = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_OPER  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

endpackage

// File: rtl/vector_fetch_unit_if.sv
// Bus bundle between the fetch unit and its neighbours: memory address/data
// ports, control (start/redirect/halted) and the issue handshake to execute.
interface vector_fetch_unit_if;
  import vm_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic [ADDR_W-1:0] mem_addr1;
  logic [ADDR_W-1:0] mem_addr2;
  logic [WORD_W-1:0] mem_data1;
  logic [WORD_W-1:0] mem_data2;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [2:0]        out_rd;
  logic [2:0]        out_rs1;
  logic [2:0]        out_rs2;
  logic [ADDR_W-1:0] out_addr;
  logic [WORD_W-1:0] out_operand;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;

  // Fetch unit side
  modport master (
    input  start, start_pc, mem_data1, mem_data2, out_ready,
           redirect_valid, redirect_pc,
    output mem_addr1, mem_addr2, out_valid, out_opcode, out_rd, out_rs1,
           out_rs2, out_addr, out_operand, out_pc, halted
  );

  // Environment side (memory, execute stage, controller)
  modport slave (
    output start, start_pc, mem_data1, mem_data2, out_ready,
           redirect_valid, redirect_pc,
    input  mem_addr1, mem_addr2, out_valid, out_opcode, out_rd, out_rs1,
           out_rs2, out_addr, out_operand, out_pc, halted
  );

endinterface

// File: rtl/vector_fetch_unit_decode.sv
// Combinational field split of a 24-bit instruction word. Also flags the
// all-zero word, which is the halt instruction.
module instr_decode
  import vm_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output instr_t            fields_o,
  output logic              is_halt_o
);

  // Split the word into its fields and detect the all-zero halt word
  always_comb begin
    fields_o.opcode = word_i[OPC_HI:OPC_LO];
    fields_o.rd     = word_i[RD_HI:RD_LO];
    fields_o.rs1    = word_i[RS1_HI:RS1_LO];
    fields_o.rs2    = word_i[RS2_HI:RS2_LO];
    fields_o.addr   = word_i[ADR_HI:ADR_LO];
    is_halt_o       = (word_i[OPC_HI:OPC_LO] == OPC_HALT) &&
                      (word_i[OPC_LO-1:0] == {(OPC_LO){1'b0}});
  end

endmodule

// File: rtl/vector_fetch_unit.sv
// Fetch/decode stage: walks the PC through instruction memory on port 1,
// fetches the addressed operand on port 2 and issues one decoded instruction
// at a time over valid/ready. Execute may redirect the PC; a zero word halts.
module vector_fetch_unit
  import vm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  vector_fetch_unit_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  instr_t            instr_q;
  logic [WORD_W-1:0] operand_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic              out_valid_q;
  logic              halted_q;
  logic [ADDR_W-1:0] mem_addr1_q;
  logic [ADDR_W-1:0] mem_addr2_q;

  instr_t            dec_fields_s;
  logic              dec_halt_s;
  logic [ADDR_W-1:0] pc_inc_s;

  // Decode straight off the instruction port so the halt test and the field
  // latch both happen in the FETCH cycle.
  instr_decode u_decode (
    .word_i    (bus.mem_data1),
    .fields_o  (dec_fields_s),
    .is_halt_o (dec_halt_s)
  );

  assign pc_inc_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Main FSM: state, PC, fetched instruction/operand and all registered outputs.
  // mem_addr1 is loaded with the target PC on every transition into FETCH so the
  // instruction port already points at pc during FETCH; mem_addr2 is loaded from
  // the fetched word on the way into OPER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= {ADDR_W{1'b0}};
      instr_q     <= '0;
      operand_q   <= {WORD_W{1'b0}};
      out_pc_q    <= {ADDR_W{1'b0}};
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      mem_addr1_q <= {ADDR_W{1'b0}};
      mem_addr2_q <= {ADDR_W{1'b0}};
    end else if (bus.redirect_valid && (state_q != ST_IDLE)) begin
      // Redirect wins over everything; an un-accepted issue is simply dropped
      state_q     <= ST_FETCH;
      pc_q        <= bus.redirect_pc;
      mem_addr1_q <= bus.redirect_pc;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_FETCH;
            pc_q        <= bus.start_pc;
            mem_addr1_q <= bus.start_pc;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (dec_halt_s) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q     <= ST_OPER;
            instr_q     <= dec_fields_s;
            mem_addr2_q <= dec_fields_s.addr;
          end
        end
        ST_OPER: begin
          state_q     <= ST_ISSUE;
          operand_q   <= bus.mem_data2;
          out_pc_q    <= pc_q;
          pc_q        <= pc_inc_s;
          out_valid_q <= 1'b1;
        end
        ST_ISSUE: begin
          if (bus.out_ready) begin
            state_q     <= ST_FETCH;
            out_valid_q <= 1'b0;
            mem_addr1_q <= pc_q;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_HALT: begin
          if (bus.start) begin
            state_q     <= ST_FETCH;
            pc_q        <= bus.start_pc;
            mem_addr1_q <= bus.start_pc;
            halted_q    <= 1'b0;
          end else begin
            state_q <= ST_HALT;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr1   = mem_addr1_q;
  assign bus.mem_addr2   = mem_addr2_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_opcode  = instr_q.opcode;
  assign bus.out_rd      = instr_q.rd;
  assign bus.out_rs1     = instr_q.rs1;
  assign bus.out_rs2     = instr_q.rs2;
  assign bus.out_addr    = instr_q.addr;
  assign bus.out_operand = operand_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_vector_fetch_unit.sv
// Bench for vector_fetch_unit: memory array model, queue of expected issued
// instructions derived from memory contents, per-cycle compare process and
// directed sequences with hand-computed literals.
module tb_vector_fetch_unit;

  logic clk;
  logic rst;
  vector_fetch_unit_if bus();

  vector_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [23:0] mem [0:511];
  assign bus.mem_data1 = mem[bus.mem_addr1];
  assign bus.mem_data2 = mem[bus.mem_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected instruction stream: the address of each instruction that should
  // leave the unit, in order. Fields and operand are derived from memory.
  logic [8:0] expq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!bus.halted && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(bus.halted), 32'd1);
  endtask

  // Compare process: every valid cycle is checked against the head of the
  // expected stream; the head leaves the stream when consumed or redirected away.
  always @(negedge clk) begin
    logic [8:0]  epc;
    logic [23:0] w;
    if (!rst) begin
      check("valid_and_halted", 32'(bus.out_valid & bus.halted), 32'd0);
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got pc %0d expected no issue", bus.out_pc);
        end else begin
          epc = expq[0];
          w   = mem[epc];
          check("m_pc",      32'(bus.out_pc),      32'(epc));
          check("m_opcode",  32'(bus.out_opcode),  32'(w[23:20]));
          check("m_rd",      32'(bus.out_rd),      32'(w[19:17]));
          check("m_rs1",     32'(bus.out_rs1),     32'(w[16:14]));
          check("m_rs2",     32'(bus.out_rs2),     32'(w[13:11]));
          check("m_addr",    32'(bus.out_addr),    32'(w[8:0]));
          check("m_operand", 32'(bus.out_operand), 32'(mem[w[8:0]]));
          if (bus.out_ready || bus.redirect_valid) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 24'h000000;
    mem[3]   = 24'b110111110000000000000101;
    mem[5]   = 24'd17;
    mem[7]   = 24'h5A4C2A;
    mem[42]  = 24'h00BEEF;
    mem[13]  = 24'h9C3864;
    mem[100] = 24'h123456;
    mem[511] = 24'h71F1FF;
    mem[0]   = 24'h2000C8;
    mem[200] = 24'hABCDEF;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_pc = 9'd0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 9'd0;
    tick();
    tick();
    check("rst_valid",  32'(bus.out_valid), 32'd0);
    check("rst_halted", 32'(bus.halted),    32'd0);
    check("rst_addr1",  32'(bus.mem_addr1), 32'd0);
    check("rst_addr2",  32'(bus.mem_addr2), 32'd0);
    check("rst_pc",     32'(bus.out_pc),    32'd0);
    rst = 1'b0;
    tick();

    // Decode + latency + backpressure
    expq.push_back(9'd3);
    bus.start = 1'b1;
    bus.start_pc = 9'd3;
    tick();
    bus.start = 1'b0;
    check("n1_addr1", 32'(bus.mem_addr1), 32'd3);
    check("n1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("n2_addr2", 32'(bus.mem_addr2), 32'd5);
    check("n2_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("n3_valid",   32'(bus.out_valid),   32'd1);
    check("n3_opcode",  32'(bus.out_opcode),  32'd13);
    check("n3_rd",      32'(bus.out_rd),      32'd7);
    check("n3_rs1",     32'(bus.out_rs1),     32'd4);
    check("n3_rs2",     32'(bus.out_rs2),     32'd0);
    check("n3_addr",    32'(bus.out_addr),    32'd5);
    check("n3_operand", 32'(bus.out_operand), 32'd17);
    check("n3_pc",      32'(bus.out_pc),      32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_addr1", 32'(bus.mem_addr1), 32'd3);
    end
    bus.out_ready = 1'b1;
    tick();
    check("next_fetch_addr1", 32'(bus.mem_addr1), 32'd4);
    check("next_fetch_valid", 32'(bus.out_valid), 32'd0);

    // Halt on zero word at 4
    tick();
    check("halt_set", 32'(bus.halted), 32'd1);
    tick();
    tick();
    check("halt_hold",  32'(bus.halted),    32'd1);
    check("halt_novld", 32'(bus.out_valid), 32'd0);

    // Restart from HALT at 7
    expq.push_back(9'd7);
    bus.start = 1'b1;
    bus.start_pc = 9'd7;
    tick();
    bus.start = 1'b0;
    check("restart_halted_clr", 32'(bus.halted), 32'd0);
    wait_valid("restart_valid");
    check("restart_pc",      32'(bus.out_pc),      32'd7);
    check("restart_operand", 32'(bus.out_operand), 32'h00BEEF);
    wait_halted("restart_halt");

    // Redirect during ISSUE: first stalled (dropped), then accepted same cycle
    for (int r = 0; r < 2; r++) begin
      bus.out_ready = (r == 1);
      expq.push_back(9'd7);
      bus.start = 1'b1;
      bus.start_pc = 9'd7;
      tick();
      bus.start = 1'b0;
      wait_valid("redir_wait");
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 9'd13;
      expq.push_back(9'd13);
      tick();
      bus.redirect_valid = 1'b0;
      check("redir_valid_drop", 32'(bus.out_valid), 32'd0);
      check("redir_addr1",      32'(bus.mem_addr1), 32'd13);
      bus.out_ready = 1'b1;
      wait_valid("redir_issue");
      check("redir_pc",      32'(bus.out_pc),      32'd13);
      check("redir_operand", 32'(bus.out_operand), 32'h123456);
      wait_halted("redir_halt");
    end

    // Wrap 511 -> 0, then asynchronous reset during OPER
    expq.push_back(9'd511);
    expq.push_back(9'd0);
    bus.start = 1'b1;
    bus.start_pc = 9'd511;
    tick();
    bus.start = 1'b0;
    wait_valid("wrap_valid");
    check("wrap_pc",      32'(bus.out_pc),      32'd511);
    check("wrap_operand", 32'(bus.out_operand), 32'h71F1FF);
    tick();
    check("wrap_fetch_addr1", 32'(bus.mem_addr1), 32'd0);
    check("wrap_fetch_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("wrap_oper_addr2", 32'(bus.mem_addr2), 32'd200);
    rst = 1'b1;
    #1;
    check("arst_valid",   32'(bus.out_valid),   32'd0);
    check("arst_halted",  32'(bus.halted),      32'd0);
    check("arst_addr1",   32'(bus.mem_addr1),   32'd0);
    check("arst_addr2",   32'(bus.mem_addr2),   32'd0);
    check("arst_opcode",  32'(bus.out_opcode),  32'd0);
    check("arst_rd",      32'(bus.out_rd),      32'd0);
    check("arst_addr",    32'(bus.out_addr),    32'd0);
    check("arst_operand", 32'(bus.out_operand), 32'd0);
    check("arst_pc",      32'(bus.out_pc),      32'd0);
    expq.delete();
    tick();
    rst = 1'b0;
    tick();

    // Redirect in IDLE is ignored
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 9'd13;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    tick();
    check("idle_redir_addr1", 32'(bus.mem_addr1), 32'd0);
    check("idle_redir_valid", 32'(bus.out_valid), 32'd0);
    check("idle_redir_halt",  32'(bus.halted),    32'd0);
    check("queue_drained",    32'(expq.size()),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
